grid_pixel_renderer: RTL
========================

# grid_pixel_renderer

Parametrised, pipelined playfield renderer for the VGA path: maps each (DrawX, DrawY) to a cell of a ROWS×COLS block grid, looks up the cell's 3-bit colour code in a fixed palette, and outputs 4-bit RGB. It supersedes the single-cycle grid colour mapper. New behaviour: configurable grid geometry and origin, empty cells that show the background, cell-edge shading, per-row flash for line-clear animation, and a registered 2-stage pipeline. It sits between the game-state grid register and the VGA output.

## Interface
- COLS, 10, grid columns
- ROWS, 18, grid rows
- CELL_W, 16, cell width in pixels; power of two
- CELL_H, 16, cell height in pixels; power of two
- X0, 240, field left edge in pixels
- Y0, 96, field top edge in pixels
- BLINK_FRAMES, 8, frames per flash half-period; at least 1

- vga_clk  in  1  pixel clock; all state on rising edge
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active display area
- bg_red, bg_green, bg_blue  in  4 each  background pixel, aligned with DrawX/DrawY
- grid_flat  in  ROWS*COLS*3  cell (r,c) code at bits [(r*COLS+c)*3 +: 3]
- row_flash  in  ROWS  1 = row r is flashing
- red, green, blue  out  4 each  registered pixel colour

## Operation
- Stage 1 (registered):
  - relX = DrawX − X0 and relY = DrawY − Y0, both 11-bit.
  - in_field = (DrawX ≥ X0) && (DrawX < X0+COLS*CELL_W) && (DrawY ≥ Y0) && (DrawY < Y0+ROWS*CELL_H).
  - col = relX >> log2(CELL_W); row = relY >> log2(CELL_H).
  - edge = (relX mod CELL_W == 0) || (relY mod CELL_H == 0).
  - Register blank and bg_* alongside these values.
- Stage 2 (registered): read code = grid_flat cell (row, col), using combinational row_flash/grid_flat values at that cycle.
- Colour priority:
  - blank=0: 000.
  - !in_field: bg.
  - row_flash[row] && phase=1: FFF.
  - code 0: bg.
  - Otherwise palette entry, halved per channel (>>1) when edge=1.
- Palette: 1 F00, 2 0F0, 3 00F, 4 FF0, 5 F0F, 6 F70, 7 F47.
- Flash timing:
  - sof = (DrawX==0 && DrawY==0) && !prev_sof, with prev_sof registered.
  - An 8-bit frame counter increments on sof. When it reaches BLINK_FRAMES−1, it clears to 0 and phase toggles.
- The flash test ignores code; flashing empty cells also turn white.

## Timing
- Latency: exactly 2 cycles from DrawX/DrawY/blank/bg_* to red/green/blue. Throughput: 1 pixel per cycle.
- Reset:
  - red/green/blue = 0.
  - All stage registers cleared (blank=0).
  - Frame counter = 0, phase = 0, prev_sof = 0.
- Reset mid-frame: outputs are 0 in the cycle after Reset samples high. The first valid pixel appears 2 cycles after Reset deasserts.
- Boundaries:
  - DrawX = X0+COLS*CELL_W−1 is the last in-field column.
  - DrawX = X0+COLS*CELL_W is background.
  - The same rule applies vertically.
  - DrawX < X0 must not wrap into the field: use the compare, not relX.
- DrawX/DrawY held at (0,0) for several cycles counts as one frame.
- row_flash change mid-frame takes effect on the next pixel that reaches stage 2. No latching.

## Test plan
- Reset held 3 cycles with arbitrary inputs -> RGB=000, phase=0. After release, drive (257,97), cell(0,1)=1, blank=1 -> F00 exactly 2 cycles later.
- Edge shading: cell(0,1)=1, pixel (256,96) -> 700. Pixel (271,111) -> F00.
- Field bounds with bg=123:
  - (239,200) -> 123.
  - (399,383), cell(17,9)=4 -> FF0.
  - (400,383) -> 123.
  - (241,384) -> 123.
  - blank=0 at (300,200) -> 000.
- Empty cell: code 0 at (300,200), bg=5A5 -> 5A5. Code 7 at the same pixel -> F47.
- Flash with BLINK_FRAMES=2, row_flash[5]=1, cell(5,3)=2, pixel (297,177):
  - Frames 0–1 -> 0F0.
  - After 2 sof pulses -> FFF.
  - After 4 -> 0F0.
  - (0,0) held 5 cycles counts as 1 frame.
- Back-to-back pixels (256..271, row 97) with alternating codes: the output sequence matches the input sequence shifted by exactly 2 cycles, with no bubbles.

Source files
------------

// File: rtl/grid_pixel_renderer_if.sv
// Pixel-stream bundle between the VGA timing/game-state side and the
// playfield renderer: pixel coordinates, background, grid state, colour out.
interface grid_pixel_renderer_if #(
  parameter int ROWS = 18,
  parameter int COLS = 10
);
  logic [9:0]             DrawX;
  logic [9:0]             DrawY;
  logic                   blank;
  logic [3:0]             bg_red;
  logic [3:0]             bg_green;
  logic [3:0]             bg_blue;
  logic [ROWS*COLS*3-1:0] grid_flat;
  logic [ROWS-1:0]        row_flash;
  logic [3:0]             red;
  logic [3:0]             green;
  logic [3:0]             blue;

  modport master (
    output DrawX, DrawY, blank, bg_red, bg_green, bg_blue, grid_flat, row_flash,
    input  red, green, blue
  );

  modport slave (
    input  DrawX, DrawY, blank, bg_red, bg_green, bg_blue, grid_flat, row_flash,
    output red, green, blue
  );
endinterface

// File: rtl/grid_pixel_renderer.sv
// Two-stage playfield renderer: maps (DrawX, DrawY) to a grid cell, looks up
// the cell colour code in a fixed palette, applies edge shading and per-row
// flash, and falls back to the background outside the field or on empty cells.
module grid_pixel_renderer #(
  parameter int COLS         = 10,
  parameter int ROWS         = 18,
  parameter int CELL_W       = 16,
  parameter int CELL_H       = 16,
  parameter int X0           = 240,
  parameter int Y0           = 96,
  parameter int BLINK_FRAMES = 8
) (
  input logic                  vga_clk,
  input logic                  Reset,
  grid_pixel_renderer_if.slave bus
);

  localparam int LOG_W = $clog2(CELL_W);
  localparam int LOG_H = $clog2(CELL_H);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BIT_W = $clog2(ROWS * COLS * 3);

  localparam logic [10:0] X_LO       = 11'(X0);
  localparam logic [10:0] X_HI       = 11'(X0 + COLS * CELL_W);
  localparam logic [10:0] Y_LO       = 11'(Y0);
  localparam logic [10:0] Y_HI       = 11'(Y0 + ROWS * CELL_H);
  localparam logic [10:0] W_MASK     = 11'(CELL_W - 1);
  localparam logic [10:0] H_MASK     = 11'(CELL_H - 1);
  localparam logic [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);

  // Stage-1 combinational terms
  logic [10:0]      x_ext, y_ext, rel_x, rel_y;
  logic             in_field_c, edge_c;
  logic [COL_W-1:0] col_c;
  logic [ROW_W-1:0] row_c;

  // Stage-1 registers
  logic             s1_in_field, s1_edge, s1_blank;
  logic [COL_W-1:0] s1_col;
  logic [ROW_W-1:0] s1_row;
  logic [11:0]      s1_bg;

  // Stage-2 combinational terms
  logic [BIT_W-1:0] bit_idx;
  logic [2:0]       code;
  logic [11:0]      pal, pix;

  // Flash timing state
  logic       sof_now, sof, prev_sof, phase;
  logic [7:0] frame_cnt;

  // Field test uses direct compares so DrawX < X0 cannot wrap into the field;
  // col/row are zeroed outside the field to keep the grid lookup in range.
  always_comb begin
    x_ext      = {1'b0, bus.DrawX};
    y_ext      = {1'b0, bus.DrawY};
    rel_x      = x_ext - X_LO;
    rel_y      = y_ext - Y_LO;
    in_field_c = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
    col_c      = in_field_c ? COL_W'(rel_x >> LOG_W) : '0;
    row_c      = in_field_c ? ROW_W'(rel_y >> LOG_H) : '0;
    edge_c     = ((rel_x & W_MASK) == '0) || ((rel_y & H_MASK) == '0);
  end

  // Stage 1: register geometry results alongside blank and background
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      s1_in_field <= 1'b0;
      s1_edge     <= 1'b0;
      s1_blank    <= 1'b0;
      s1_col      <= '0;
      s1_row      <= '0;
      s1_bg       <= '0;
    end else begin
      s1_in_field <= in_field_c;
      s1_edge     <= edge_c;
      s1_blank    <= bus.blank;
      s1_col      <= col_c;
      s1_row      <= row_c;
      s1_bg       <= {bus.bg_red, bus.bg_green, bus.bg_blue};
    end
  end

  // Stage-2 lookup and colour priority: blank, background, flash, empty, palette
  always_comb begin
    bit_idx = BIT_W'((32'(s1_row) * COLS + 32'(s1_col)) * 3);
    code    = bus.grid_flat[bit_idx +: 3];
    case (code)
      3'd1:    pal = 12'hF00;
      3'd2:    pal = 12'h0F0;
      3'd3:    pal = 12'h00F;
      3'd4:    pal = 12'hFF0;
      3'd5:    pal = 12'hF0F;
      3'd6:    pal = 12'hF70;
      3'd7:    pal = 12'hF47;
      default: pal = 12'h000;
    endcase
    if (!s1_blank)
      pix = '0;
    else if (!s1_in_field)
      pix = s1_bg;
    else if (bus.row_flash[s1_row] && phase)
      pix = '1;
    else if (code == 3'd0)
      pix = s1_bg;
    else if (s1_edge)
      pix = {1'b0, pal[11:9], 1'b0, pal[7:5], 1'b0, pal[3:1]};
    else
      pix = pal;
  end

  // Stage 2: registered colour output
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      bus.red   <= '0;
      bus.green <= '0;
      bus.blue  <= '0;
    end else begin
      {bus.red, bus.green, bus.blue} <= pix;
    end
  end

  // A run of (0,0) pixels yields a single start-of-frame pulse on its first cycle
  always_comb begin
    sof_now = (bus.DrawX == '0) && (bus.DrawY == '0);
    sof     = sof_now && !prev_sof;
  end

  // Frame counter and flash phase, advanced once per frame
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      prev_sof  <= 1'b0;
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      prev_sof <= sof_now;
      if (sof) begin
        if (frame_cnt >= FRAME_LAST) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule
